// File: rtl/fib_job_dispatcher_if.sv
// Job stream, core four-phase handshake and result stream
// of the Fibonacci job dispatcher.
`timescale 1ns/1ps
interface fib_job_dispatcher_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_n;
    logic             req;
    logic [WIDTH-1:0] n_out;
    logic             fin;
    logic [WIDTH-1:0] result_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [WIDTH-1:0] out_n;
    logic             busy;
    logic             stall;

    modport slave (
        input  in_valid, in_n, fin, result_in, out_ready,
        output in_ready, req, n_out, out_valid,
        output out_result, out_n, busy, stall
    );

    modport master (
        output in_valid, in_n, fin, result_in, out_ready,
        input  in_ready, req, n_out, out_valid,
        input  out_result, out_n, busy, stall
    );
endinterface

// File: rtl/fib_job_dispatcher.sv
// Clocked front end for the self-timed fibonacci core: job intake,
// four-phase req/fin handshake with synchronised fin, result slot.
`timescale 1ns/1ps
module fib_job_dispatcher #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    fib_job_dispatcher_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RISE,
        S_FALL,
        S_HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_prime;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_n_out;
    logic [WIDTH-1:0]       r_res_q;
    logic [WIDTH-1:0]       r_n_q;
    logic [WIDTH-1:0]       r_out_result;
    logic [WIDTH-1:0]       r_out_n;
    logic                   r_req;
    logic                   r_out_valid;
    logic                   r_stall;

    logic w_fin_s;
    logic w_primed;
    logic w_slot_free;
    logic w_accept;
    logic w_capture;
    logic w_load;
    logic w_cnt_clr;
    logic w_phase;

    assign w_fin_s     = r_sync[SYNC_STAGES-1];
    // fin_s is meaningless until the synchroniser has refilled after reset
    assign w_primed    = r_prime[SYNC_STAGES-1];
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_phase     = (r_state == S_RISE) || (r_state == S_FALL);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_load    = 1'b0;
        w_cnt_clr = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid && w_primed && !w_fin_s) begin
                    w_accept  = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = S_RISE;
                end
            end
            S_RISE: begin
                if (w_fin_s) begin
                    w_capture = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = S_FALL;
                end
            end
            S_FALL: begin
                if (!w_fin_s) begin
                    if (w_slot_free) begin
                        w_load = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_slot_free) begin
                    w_load = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_prime <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.fin};
            r_prime <= {r_prime[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req        <= 1'b0;
            r_n_out      <= '0;
            r_res_q      <= '0;
            r_n_q        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_n      <= '0;
            r_cnt        <= '0;
            r_stall      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_n_out <= bus.in_n;
                r_req   <= 1'b1;
            end
            if (w_capture) begin
                r_res_q <= bus.result_in;
                r_n_q   <= r_n_out;
                r_req   <= 1'b0;
            end
            if (w_load) begin
                r_out_result <= r_res_q;
                r_out_n      <= r_n_q;
                r_out_valid  <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid  <= 1'b0;
            end
            // Timeout only flags; the handshake must never be abandoned
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_phase) begin
                if (r_cnt != CW'(TIMEOUT))
                    r_cnt <= r_cnt + 1'b1;
                if (r_cnt >= CW'(TIMEOUT - 1))
                    r_stall <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE) && !w_fin_s && w_primed;
    assign bus.req        = r_req;
    assign bus.n_out      = r_n_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_n      = r_out_n;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.stall      = r_stall;
endmodule

// File: tb/tb_fib_job_dispatcher.sv
// Scoreboard bench for fib_job_dispatcher with a behavioural
// self-timed core model driving fin/result_in.
`timescale 1ns/1ps
module tb_fib_job_dispatcher;
    localparam int W    = 32;
    localparam int SYNC = 2;
    localparam int TO   = 50;

    typedef struct packed {
        logic [W-1:0] n;
        logic [W-1:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fib_job_dispatcher_if #(.WIDTH(W)) bus ();

    fib_job_dispatcher #(
        .WIDTH(W),
        .SYNC_STAGES(SYNC),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    logic ready_ctl = 1'b1;
    logic rnd_mode = 1'b0;
    logic rbit = 1'b1;
    assign bus.out_ready = rnd_mode ? rbit : ready_ctl;

    logic hang = 1'b0;
    logic rnd_dly = 1'b0;
    int   rise_fix = 37;
    int   fall_fix = 20;

    int   req_rises = 0;
    int   accepts = 0;
    int   fin_low_edges = 0;
    int   bnd_viol = 0;
    logic bnd_phase = 1'b0;

    function automatic logic [W-1:0] fib(input int n);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] t;
        a = 1;
        b = 1;
        for (int i = 1; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // keep core edges off the clock edges
    function automatic real dly(input int d);
        return (d % 10 == 0) ? real'(d) + 0.5 : real'(d);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // core model: garbage on result_in until fin rises
    initial begin : core
        logic [W-1:0] n_lat;
        int d;
        bus.fin = 1'b0;
        bus.result_in = '0;
        forever begin
            @(posedge bus.req);
            n_lat = bus.n_out;
            bus.result_in = 32'hDEADBEEF;
            wait (!hang);
            d = rnd_dly ? int'($urandom_range(200, 1)) : rise_fix;
            #(dly(d));
            bus.result_in = fib(int'(n_lat));
            bus.fin = 1'b1;
            if (bus.req) @(negedge bus.req);
            d = rnd_dly ? int'($urandom_range(200, 1)) : fall_fix;
            #(dly(d));
            bus.fin = 1'b0;
        end
    end

    always @(posedge bus.req) req_rises++;

    always @(posedge clk)
        fin_low_edges <= bus.fin ? 0 : fin_low_edges + 1;

    always begin
        @(posedge clk);
        #2;
        rbit = 1'($urandom_range(1, 0));
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.in_valid && bus.in_ready) accepts++;
        if (bnd_phase && bus.busy && bus.in_ready) bnd_viol++;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_empty: got n=%0d result=%0d, expected no output",
                         bus.out_n, bus.out_result);
            end else begin
                e = sb.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk("out_n", bus.out_n, e.n);
            end
        end
    end

    task automatic send(input logic [W-1:0] n, input logic [W-1:0] r,
                        input bit track);
        bus.in_n = n;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (track) sb.push_back(exp_t'{n: n, res: r});
                tick(1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        $display("FAIL accept_timeout: got no accept for n=%0d, expected accept", n);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy && !bus.out_valid) return;
        end
        n_checks++;
        $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        bus.in_valid = 1'b0;
        bus.in_n = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", bus.req, 0);
        chk("rst_n_out", bus.n_out, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        tick(1);
        rst = 1'b0;
        tick(3);

        // single job, N=44
        base = req_rises;
        send(44, 1134903170, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("single_valid", bus.out_valid, 1);
        chk("single_lat", fin_low_edges, SYNC + 1);
        wait_drain(200);
        chk("single_req_pulses", req_rises - base, 1);

        // boundaries
        tick(1);
        bnd_phase = 1'b1;
        send(0, 1, 1);
        send(1, 1, 1);
        send(10, 89, 1);
        wait_drain(200);
        bnd_phase = 1'b0;
        chk("bnd_in_ready_low", bnd_viol, 0);

        // backpressure
        tick(1);
        ready_ctl = 1'b0;
        send(5, 8, 1);
        repeat (30) @(negedge clk);
        tick(1);
        send(6, 13, 1);
        repeat (30) @(negedge clk);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_result", bus.out_result, 8);
        chk("bp_n", bus.out_n, 5);
        chk("bp_busy", bus.busy, 1);
        chk("bp_req", bus.req, 0);
        chk("bp_res_q", dut.r_res_q, 13);
        tick(1);
        ready_ctl = 1'b1;
        tick(1);
        ready_ctl = 1'b0;
        @(negedge clk);
        chk("bp_nobubble_valid", bus.out_valid, 1);
        chk("bp_next_result", bus.out_result, 13);
        chk("bp_next_n", bus.out_n, 6);
        chk("bp_idle", bus.busy, 0);
        tick(1);
        ready_ctl = 1'b1;
        wait_drain(200);

        // random delays and indices
        tick(1);
        base = req_rises;
        rnd_dly = 1'b1;
        rnd_mode = 1'b1;
        for (int j = 0; j < 200; j++) begin
            k = int'($urandom_range(46, 0));
            send(k, fib(k), 1);
        end
        tick(1);
        rnd_mode = 1'b0;
        wait_drain(2000);
        rnd_dly = 1'b0;
        chk("rnd_req_rises", req_rises - base, 200);
        chk("rnd_no_stall", bus.stall, 0);

        // timeout
        tick(1);
        hang = 1'b1;
        rise_fix = 37;
        send(7, 21, 1);
        @(negedge clk);
        chk("to_req_up", bus.req, 1);
        repeat (49) @(negedge clk);
        chk("to_stall_pre", bus.stall, 0);
        @(negedge clk);
        chk("to_stall_at", bus.stall, 1);
        repeat (20) @(negedge clk);
        chk("to_req_held", bus.req, 1);
        tick(1);
        hang = 1'b0;
        wait_drain(200);
        chk("to_stall_sticky", bus.stall, 1);
        chk("to_req_done", bus.req, 0);

        // reset mid-handshake with fin high
        tick(1);
        hang = 1'b1;
        rise_fix = 2;
        fall_fix = 43;
        send(9, 0, 0);
        tick(2);
        hang = 1'b0;
        @(negedge clk);
        chk("mr_rise", bus.req, 1);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_fin_high", bus.fin, 1);
        chk("mr_req", bus.req, 0);
        chk("mr_n_out", bus.n_out, 0);
        chk("mr_out_valid", bus.out_valid, 0);
        chk("mr_out_result", bus.out_result, 0);
        chk("mr_out_n", bus.out_n, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_stall", bus.stall, 0);
        chk("mr_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("mr_in_ready_seq", bus.in_ready, (fin_low_edges >= SYNC) ? 1 : 0);
        end

        // recovery
        tick(1);
        rise_fix = 37;
        fall_fix = 20;
        send(3, 3, 1);
        wait_drain(200);
        chk("sb_empty_end", sb.size(), 0);
        chk("req_per_accept", req_rises, accepts);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
